serial_add2_seq: RTL

- Multi-cycle sequencer that adds two WIDTH-bit operands using a single 2-bit adder slice, one 2-bit digit per clock, LSB digit first.
- Holds the operand and result shift registers and the carry flop.
- Provides a start/busy/done handshake so arithmetic blocks can share one small adder datapath instead of a full-width adder.

---
 rtl/serial_add2_seq_pkg.sv | 15 +
 rtl/add2_slice.sv | 24 ++
 rtl/serial_add2_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/serial_add2_seq_pkg.sv
// ---------------------------------------------------------------------------
// serial_add2_seq_pkg
// Shared constants for the digit-serial adder: digit width and the FSM state
// encodings used by serial_add2_seq.
// ---------------------------------------------------------------------------
package serial_add2_seq_pkg;

    // Bits consumed per clock by the adder slice.
    localparam int DIGIT_W = 2;

    // Sequencer states.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/add2_slice.sv
// ---------------------------------------------------------------------------
// add2_slice
// Purely combinational 2-bit + 2-bit + carry-in adder.
//   i_a, i_b : 2-bit digits
//   i_c      : carry-in
//   o_d      : 2-bit sum digit
//   o_c      : carry-out
// ---------------------------------------------------------------------------
module add2_slice
    import serial_add2_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_a,
    input  logic [DIGIT_W-1:0] i_b,
    input  logic               i_c,
    output logic [DIGIT_W-1:0] o_d,
    output logic               o_c
);

    logic [DIGIT_W:0] w_full;

    assign w_full   = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT_W{1'b0}}, i_c};
    assign {o_c, o_d} = w_full;

endmodule

// File: rtl/serial_add2_seq.sv
// ---------------------------------------------------------------------------
// serial_add2_seq
// Adds two WIDTH-bit operands one 2-bit digit per clock (LSB digit first)
// through a single add2_slice. WIDTH must be even and >= 2.
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, accepted only while busy=0
//   a, b, cin    : operands and carry-in, sampled at the accept edge
//   abort        : cancels an in-flight add (no done pulse, result untouched)
//   busy         : high while RUN
//   done         : one-cycle pulse when sum/cout become valid
//   sum, cout    : result, held until the next completion
// ---------------------------------------------------------------------------
module serial_add2_seq
    import serial_add2_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N     = WIDTH / DIGIT_W;
    localparam int CNT_W = $clog2(N) + 1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [DIGIT_W-1:0] w_d;
    logic               w_c;
    logic [WIDTH-1:0]   w_res_next;

    add2_slice u_slice (
        .i_a (r_sa[DIGIT_W-1:0]),
        .i_b (r_sb[DIGIT_W-1:0]),
        .i_c (r_carry),
        .o_d (w_d),
        .o_c (w_c)
    );

    // New digit enters at the top; after N shifts the register holds the
    // full sum with the first digit at the LSB. Written as shift/or so it
    // also elaborates for WIDTH=2, where there is no upper slice to keep.
    assign w_res_next = (r_res >> DIGIT_W) | (WIDTH'(w_d) << (WIDTH - DIGIT_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // abort is meaningless here, so start always wins.
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_carry <= cin;
                        r_cnt   <= CNT_W'(N - 1);
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_carry <= w_c;
                        r_res   <= w_res_next;
                        r_sa    <= r_sa >> DIGIT_W;
                        r_sb    <= r_sb >> DIGIT_W;
                        r_cnt   <= r_cnt - CNT_W'(1);
                        if (r_cnt == '0) begin
                            r_sum   <= w_res_next;
                            r_cout  <= w_c;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
